// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between m0 (CPU) and m1 (DMA/debug).
// Optional write/reject trace printing is enabled by defining DM_ARB_TRACE_EN.
`timescale 1ns/1ps
module dm_arbiter #(
    parameter int DEPTH = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_pc,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);
    localparam logic [29:0] DepthWords = 30'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic        we_q, we_d;
    logic        bad_q, bad_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;

    logic busy, ack0, ack1, cand0, cand1, winner;

    assign busy = (state_q == BUSY);
    assign ack0 = busy & ~owner_q;
    assign ack1 = busy & owner_q;
    // The master finishing this cycle still holds req; it must not be re-granted on the same edge.
    assign cand0 = m0_req & ~ack0;
    assign cand1 = m1_req & ~ack1;
    assign winner = (cand0 & cand1) ? rr_q : cand1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        rr_d    = rr_q;
        we_d    = we_q;
        bad_d   = bad_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        if (cand0 | cand1) begin
            state_d = BUSY;
            owner_d = winner;
            rr_d    = ~winner;
            we_d    = winner ? m1_we    : m0_we;
            addr_d  = winner ? m1_addr  : m0_addr;
            wdata_d = winner ? m1_wdata : m0_wdata;
            pc_d    = winner ? m1_pc    : m0_pc;
            bad_d   = (addr_d[1:0] != 2'b00) || (addr_d[31:2] >= DepthWords);
        end
    end

    // Rejected accesses are acknowledged with err but never drive the memory.
    assign dm_we    = busy & we_q & ~bad_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign dm_pc    = pc_q;

    assign m0_ack   = ack0;
    assign m0_err   = ack0 & bad_q;
    assign m0_rdata = (ack0 & ~bad_q) ? dm_rdata : 32'h0;
    assign m1_ack   = ack1;
    assign m1_err   = ack1 & bad_q;
    assign m1_rdata = (ack1 & ~bad_q) ? dm_rdata : 32'h0;

`ifdef DM_ARB_TRACE_EN
    always @(posedge clk) begin
        if (dm_we)
            $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, dm_wdata);
        else if (busy && bad_q)
            $display("%d@%h: DM reject %h", $time, dm_pc, dm_addr);
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then randomized traffic against
// a transaction-level reference model with its own copy of memory contents.
`timescale 1ns/1ps
module tb_dm_arbiter;
    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_pc = '0;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_pc = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err, dm_we;
    logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic        dmInit = 1'b1;

    logic [31:0] dmMem  [DEPTH];
    logic [31:0] refMem [DEPTH];

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding granted access (if any) plus the round-robin favourite.
    bit          expBusy, expOwner, expRr, expWe, expBad;
    logic [31:0] expAddr, expWdata, expPc;

    dm_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with combinational read.
    assign dm_rdata = (dm_addr[31:2] < 30'(DEPTH)) ? dmMem[dm_addr[13:2]] : 32'h0;
    always @(posedge clk) begin
        if (dmInit) begin
            for (int i = 0; i < DEPTH; i++) dmMem[i] <= 32'h0;
        end else if (dm_we && dm_addr[31:2] < 30'(DEPTH)) begin
            dmMem[dm_addr[13:2]] <= dm_wdata;
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        expBusy = 0; expOwner = 0; expRr = 0; expWe = 0; expBad = 0;
        expAddr = '0; expWdata = '0; expPc = '0;
    endtask

    // What happens at a rising edge: the finishing store lands, then the next grant is chosen.
    task automatic modelEdge();
        bit c0, c1, w;
        if (expBusy && expWe && !expBad) refMem[expAddr[13:2]] = expWdata;
        c0 = m0_req && !(expBusy && expOwner == 0);
        c1 = m1_req && !(expBusy && expOwner == 1);
        if (c0 || c1) begin
            w = (c0 && c1) ? expRr : c1;
            expBusy = 1; expOwner = w; expRr = !w;
            expWe    = w ? m1_we    : m0_we;
            expAddr  = w ? m1_addr  : m0_addr;
            expWdata = w ? m1_wdata : m0_wdata;
            expPc    = w ? m1_pc    : m0_pc;
            expBad   = (expAddr % 4 != 0) || ((expAddr / 4) >= DEPTH);
        end else begin
            expBusy = 0;
        end
    endtask

    task automatic checkOutput();
        logic [31:0] expRd;
        bit a0, a1;
        a0 = expBusy && !expOwner;
        a1 = expBusy && expOwner;
        expRd = (expBusy && !expBad) ? refMem[expAddr[13:2]] : 32'h0;
        checkValue("m0_ack",   {31'b0, m0_ack}, {31'b0, a0});
        checkValue("m1_ack",   {31'b0, m1_ack}, {31'b0, a1});
        checkValue("m0_err",   {31'b0, m0_err}, {31'b0, a0 && expBad});
        checkValue("m1_err",   {31'b0, m1_err}, {31'b0, a1 && expBad});
        checkValue("m0_rdata", m0_rdata, a0 ? expRd : 32'h0);
        checkValue("m1_rdata", m1_rdata, a1 ? expRd : 32'h0);
        checkValue("dm_we",    {31'b0, dm_we}, {31'b0, expBusy && expWe && !expBad});
        checkValue("dm_addr",  dm_addr, expAddr);
        checkValue("dm_wdata", dm_wdata, expWdata);
        checkValue("dm_pc",    dm_pc, expPc);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input bit who, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        if (!who) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_pc = 32'h0;
        end
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();
    endtask

    task automatic randRequest(output bit we, output logic [31:0] addr, output logic [31:0] wdata);
        int kind;
        kind  = $urandom_range(0, 9);
        we    = $urandom_range(0, 1) == 1;
        wdata = $urandom;
        case (kind)
            0:       addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            1:       addr = 32'h3000 + 32'($urandom_range(0, 64) * 4);
            2:       addr = 32'h2FFC;
            3:       addr = $urandom | 32'h8000_0000;
            default: addr = 32'($urandom_range(0, 31) * 4);
        endcase
    endtask

    task automatic driveRandom(input bit who, input bit ackedPrev);
        bit curReq, we;
        logic [31:0] addr, wdata;
        curReq = who ? m1_req : m0_req;
        if (ackedPrev || !curReq) begin
            if ($urandom_range(0, 9) < 6) begin
                randRequest(we, addr, wdata);
                applyStimulus(who, 1, we, addr, wdata, $urandom);
            end else begin
                applyStimulus(who, 0, 0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        bit pa0, pa1;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        dmInit = 1'b0;
        reset = 1'b0;

        // Store then load on m0.
        applyStimulus(0, 1, 1, 32'h10, 32'hDEADBEEF, 32'h100);
        cycle();
        checkValue("t1_store_ack", {31'b0, m0_ack}, 32'h1);
        checkValue("t1_store_we", {31'b0, dm_we}, 32'h1);
        cycle();
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 32'h104);
        cycle();
        checkValue("t1_load_ack", {31'b0, m0_ack}, 32'h1);
        checkValue("t1_load_rdata", m0_rdata, 32'hDEADBEEF);
        checkValue("t1_load_err", {31'b0, m0_err}, 32'h0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        cycle();

        // Simultaneous requests after reset alternate m0, m1, m0, m1.
        resetDut();
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 32'h200);
        applyStimulus(1, 1, 0, 32'h14, 32'h0, 32'h0);
        cycle();
        checkValue("t2_first_m0", {30'b0, m1_ack, m0_ack}, 32'h1);
        cycle();
        checkValue("t2_second_m1", {30'b0, m1_ack, m0_ack}, 32'h2);
        cycle();
        checkValue("t2_third_m0", {30'b0, m1_ack, m0_ack}, 32'h1);
        cycle();
        checkValue("t2_fourth_m1", {30'b0, m1_ack, m0_ack}, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        cycle();

        // Out-of-range store from m1 is rejected.
        applyStimulus(1, 1, 1, 32'h3000, 32'hCAFEF00D, 32'h0);
        cycle();
        checkValue("t3_ack", {31'b0, m1_ack}, 32'h1);
        checkValue("t3_err", {31'b0, m1_err}, 32'h1);
        checkValue("t3_we", {31'b0, dm_we}, 32'h0);
        checkValue("t3_rdata", m1_rdata, 32'h0);
        cycle();
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Misaligned load from m0, then an aligned one proceeds normally.
        applyStimulus(0, 1, 0, 32'h6, 32'h0, 32'h300);
        cycle();
        checkValue("t4_err", {31'b0, m0_err}, 32'h1);
        checkValue("t4_rdata", m0_rdata, 32'h0);
        cycle();
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 32'h304);
        cycle();
        checkValue("t4_next_err", {31'b0, m0_err}, 32'h0);
        checkValue("t4_next_rdata", m0_rdata, 32'hDEADBEEF);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        cycle();

        // Reset lands before the pending store's commit edge.
        applyStimulus(0, 1, 1, 32'h20, 32'h12345678, 32'h400);
        cycle();
        checkValue("t5_we_before", {31'b0, dm_we}, 32'h1);
        #2;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        modelReset();
        #1;
        checkValue("t5_ack_drop", {31'b0, m0_ack}, 32'h0);
        checkValue("t5_we_drop", {31'b0, dm_we}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkValue("t5_no_commit", dmMem[8], 32'h0);
        applyStimulus(0, 1, 0, 32'h20, 32'h0, 32'h500);
        applyStimulus(1, 1, 0, 32'h24, 32'h0, 32'h0);
        cycle();
        checkValue("t5_post_m0", {30'b0, m1_ack, m0_ack}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        cycle();
        checkValue("t5_post_m1", {30'b0, m1_ack, m0_ack}, 32'h2);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Randomized traffic from both masters.
        for (int c = 0; c < 600; c++) begin
            pa0 = expBusy && !expOwner;
            pa1 = expBusy && expOwner;
            cycle();
            driveRandom(0, pa0);
            driveRandom(1, pa1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU memory stage (port m0) and a secondary master such as a DMA/debug loader (port m1). It latches one request per cycle, issues it to the DM through registered address/data/write-enable signals, and returns a one-cycle acknowledge with read data to the winner. Priority is round-robin. Illegal accesses are rejected with an error flag and never reach the DM.

## Interface
- DEPTH, 3072, DM size in 32-bit words; legal word index is addr[31:2] < DEPTH
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- m0_req / m1_req  input  1  access request, held until ack
- m0_we / m1_we  input  1  1 = store word, 0 = load word
- m0_addr / m1_addr  input  32  byte address
- m0_wdata / m1_wdata  input  32  store data
- m0_pc / m1_pc  input  32  tag forwarded to DM for trace (m1 drives 0)
- m0_ack / m1_ack  output  1  one-cycle completion strobe
- m0_err / m1_err  output  1  valid with ack; access rejected
- m0_rdata / m1_rdata  output  32  load data, valid with ack
- dm_we  output  1  DM write enable
- dm_addr  output  32  DM byte address
- dm_wdata  output  32  DM write data
- dm_pc  output  32  DM PC tag
- dm_rdata  input  32  DM combinational read data

## Operation
- States: IDLE, BUSY. Registers: owner (0/1), latched we/addr/wdata/pc, bad flag, rr pointer (master with priority next).
- Arbitration each rising edge when state is IDLE, or BUSY with the current owner's ack completing: candidates are masters with req=1, excluding the master acked in the current cycle (its req is still high from the just-finished access).
- One candidate: it wins. Two: the master equal to rr wins; rr then points to the loser.
- Win: latch that master's we/addr/wdata/pc, set owner, go/stay BUSY. No winner: go IDLE.
- bad = addr[1:0] != 0 or addr[31:2] >= DEPTH, computed at latch time.
- In BUSY: dm_addr/dm_wdata/dm_pc = latched values; dm_we = latched we & ~bad; owner's ack = 1, err = bad, rdata = bad ? 0 : dm_rdata. Non-owner ack/err = 0, rdata = 0.
- In IDLE: dm_we = 0, all acks/errs = 0, rdata = 0; dm_addr/dm_wdata/dm_pc hold last latched values.
- Master rule: after seeing ack, a master drops req or changes it to a new request in the next cycle; a req still high in the cycle after ack is a new access.

## Timing
- Request sampled high at edge N (while arbiter free) -> ack during cycle N..N+1; store commits into DM at edge N+1.
- Throughput: one access per cycle; alternating masters under contention get back-to-back grants with no idle cycle.
- Same master requesting alone continuously: one ack every 2 cycles (ack cycle excluded from re-arbitration).
- Load data is combinational from DM within the ack cycle; no extra latency.
- Reset (any time, asynchronous): state IDLE, rr = 0 (m0 first), owner 0, latched regs 0, bad 0; all acks/errs/rdata 0, dm_we 0 immediately. An in-flight store is dropped if reset asserts before its commit edge. DM contents are not touched by the arbiter.
- Simultaneous first requests after reset: m0 wins, then m1.

## Configuration
- DM_ARB_TRACE_EN defined: on each committed write (dm_we=1 at rising edge) print "%d@%h: *%h <= %h" with $time, dm_pc, dm_addr, dm_wdata; rejected accesses print "%d@%h: DM reject %h" instead.
- Undefined: no display statements; logic identical.

## Test plan
- Reset, m0 store addr 0x10 data 0xDEADBEEF, then m0 load 0x10 -> m0_ack one cycle after each request, load m0_rdata = 0xDEADBEEF, m0_err = 0.
- m0 and m1 assert req in the same cycle after reset -> m0 acked first cycle, m1 acked the next, rr then favors m0; held reqs alternate m0,m1,m0 every cycle.
- m1 store addr 0x3000 (word 3072, DEPTH=3072) -> m1_ack=1, m1_err=1, dm_we stays 0, m1_rdata = 0.
- m0 load addr 0x6 (misaligned) -> m0_err=1, no DM access effects, next aligned request proceeds normally.
- Assert reset while BUSY with pending store 0x20<=0x12345678 before commit edge -> acks and dm_we drop to 0 immediately, DM word 0x20 unchanged, first post-reset contention granted to m0.
